// File: rtl/led_seq_pkg.sv
// Shared mode codes, per-mode step moduli and the (mode, step) to LED pattern decode
// for the LED pattern sequencer.
package led_seq_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_BLINK  = 3'd1,
        MODE_CHASE  = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_BINARY = 3'd4
    } mode_e;

    localparam mode_e MODE_LAST = MODE_BINARY;

    localparam logic [4:0] MOD_OFF    = 5'd1;
    localparam logic [4:0] MOD_BLINK  = 5'd2;
    localparam logic [4:0] MOD_CHASE  = 5'd4;
    localparam logic [4:0] MOD_BOUNCE = 5'd6;
    localparam logic [4:0] MOD_BINARY = 5'd16;

    function automatic logic [4:0] step_modulus(input logic [2:0] mode);
        case (mode)
            MODE_BLINK:  return MOD_BLINK;
            MODE_CHASE:  return MOD_CHASE;
            MODE_BOUNCE: return MOD_BOUNCE;
            MODE_BINARY: return MOD_BINARY;
            default:     return MOD_OFF;
        endcase
    endfunction

    // Bit 0 is LED_1; unreachable mode codes decode as OFF.
    function automatic logic [3:0] led_decode(input logic [2:0] mode, input logic [3:0] step);
        case (mode)
            MODE_BLINK:  return {4{step[0]}};
            MODE_CHASE:  return 4'b0001 << step[1:0];
            MODE_BOUNCE: begin
                case (step)
                    4'd0:    return 4'b0001;
                    4'd1:    return 4'b0010;
                    4'd2:    return 4'b0100;
                    4'd3:    return 4'b1000;
                    4'd4:    return 4'b0100;
                    4'd5:    return 4'b0010;
                    default: return 4'b0000;
                endcase
            end
            MODE_BINARY: return step;
            default:     return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Prescaler for the LED sequencer: a one-cycle tick every TICK_LIMIT enabled cycles,
// frozen while disabled and restartable from zero with i_Clear.
module led_tick_gen #(
    parameter int TICK_LIMIT = 12500000,
    parameter int CNT_WIDTH  = $clog2(TICK_LIMIT)
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic i_Enable,
    input  logic i_Clear,
    output logic o_Tick
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TICK_LIMIT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Clear wins over enable so a mode change restarts the full period even while paused.
    always_comb begin
        cnt_d = cnt_q;
        if (i_Clear) begin
            cnt_d = '0;
        end else if (i_Enable) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Tick = i_Enable & (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_pattern_sequencer.sv
// Four-LED pattern sequencer: button edge steps through OFF/BLINK/CHASE/BOUNCE/BINARY,
// the shared prescaler tick paces the pattern step, LEDs are a registered decode.
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_LIMIT = 12500000,
    parameter int CNT_WIDTH  = $clog2(TICK_LIMIT)
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Next,
    input  logic       i_Pause,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [2:0] o_Mode
);

    logic       next_dly_q;
    mode_e      mode_q;
    mode_e      mode_d;
    logic [3:0] step_q;
    logic [3:0] step_d;
    logic [4:0] step_inc;
    logic [3:0] led_q;
    logic       advance;
    logic       tick;

    // next_dly_q resets high so a button held through reset release is not an advance.
    assign advance = i_Next & ~next_dly_q;

    led_tick_gen #(
        .TICK_LIMIT (TICK_LIMIT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_tick_gen (
        .i_Clock  (i_Clock),
        .i_Rst_L  (i_Rst_L),
        .i_Enable (~i_Pause),
        .i_Clear  (advance),
        .o_Tick   (tick)
    );

    assign mode_d   = (mode_q >= MODE_LAST) ? MODE_OFF : mode_e'(mode_q + 3'd1);
    assign step_inc = {1'b0, step_q} + 5'd1;
    assign step_d   = (step_inc >= step_modulus(mode_q)) ? 4'd0 : step_inc[3:0];

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            next_dly_q <= 1'b1;
            mode_q     <= MODE_OFF;
            step_q     <= 4'd0;
            led_q      <= 4'd0;
        end else begin
            next_dly_q <= i_Next;
            led_q      <= led_decode(mode_q, step_q);
            if (advance) begin
                mode_q <= mode_d;
                step_q <= 4'd0;
            end else if (tick) begin
                step_q <= step_d;
            end
        end
    end

    assign o_LED_1 = led_q[0];
    assign o_LED_2 = led_q[1];
    assign o_LED_3 = led_q[2];
    assign o_LED_4 = led_q[3];
    assign o_Mode  = mode_q;

endmodule
